// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/busy/done handshake and data bundle for bin2bcd_seq
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (output start, bin_in, input busy, done, bcd_out);
  modport slave  (input start, bin_in, output busy, done, bcd_out);
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD converter
module bin2bcd_seq #(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  bin2bcd_seq_if.slave  bus
);
  localparam int SW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  if (((2**WIDTH) - 1) > ((10**DIGITS) - 1)) begin : g_width_check
    $fatal(1, "bin2bcd_seq: WIDTH too large for DIGITS");
  end

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [SW-1:0]       adj;
  logic [SW-1:0]       shifted;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  // Add-3 on every BCD digit >= 5 before the shift; max 9+3 so no digit overflow.
  always_comb begin
    adj = sr_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_q[WIDTH + 4*d +: 4] >= 4'd5) begin
        adj[WIDTH + 4*d +: 4] = sr_q[WIDTH + 4*d +: 4] + 4'd3;
      end
    end
    shifted = adj << 1;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = {{(4*DIGITS){1'b0}}, bus.bin_in};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        sr_d  = shifted;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = shifted[SW-1 -: 4*DIGITS];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter downstream of the ADC data stage. It consumes a 13-bit unsigned result (voltage in mV or distance) and produces four packed BCD digits for the seven-segment display driver. It uses the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock, with a start/busy/done handshake. The last result is held stable between conversions.

Parameters:
WIDTH, 13, bit width of the binary input; must satisfy 2^WIDTH-1 <= 10^DIGITS-1 (elaboration-time check, fatal if violated)
DIGITS, 4, number of BCD output digits

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only when idle
bin_in  input  WIDTH  unsigned binary value, captured on the accepting edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse: bcd_out has just been updated
bcd_out  output  4*DIGITS  packed BCD, digit 0 (ones) in [3:0], digit DIGITS-1 most significant

Behaviour:
- Reset (async, reset_n=0): state=IDLE, busy=0, done=0, bcd_out=0, shift register and bit counter cleared. Reset takes effect immediately, including mid-conversion; no partial result is ever written to bcd_out.
- Internal: shift register of 4*DIGITS+WIDTH bits (BCD field above binary field); bit counter of ceil(log2(WIDTH+1)) bits.
- States: IDLE, CONVERT.
- IDLE: on an edge with start=1, load binary field=bin_in and BCD field=0, counter=0, go to CONVERT, busy<=1. With start=0, stay in IDLE.
- CONVERT, each edge: for every BCD digit >= 5, add 3 to that digit (combinational, all digits in parallel); then shift the whole register left by 1; counter+1.
- On the edge that performs shift number WIDTH: bcd_out<=adjusted-and-shifted BCD field, done<=1, busy<=0, state<=IDLE.
- Latency: with the accept on edge 0, shifts occur on edges 1..WIDTH. done is high for exactly the cycle after edge WIDTH (13 cycles after accept at default). busy is high from after edge 0 until edge WIDTH.
- done is registered, high for exactly one cycle, and cleared on the next edge unless another conversion completes.
- start while busy=1 is ignored: no queuing, and bin_in changes have no effect on the conversion in flight.
- start=1 in the cycle where done=1: state is IDLE, so it is accepted. Back-to-back throughput is one result per WIDTH+1 cycles.
- start held continuously high: conversions repeat back-to-back.
- bcd_out changes only on a done edge or on reset. Each digit is always in 0..9.
- No arithmetic wrap: the add-3 is applied only to digits in 5..9, so results stay within 8..12 before the shift.

Test Plan:
- Reset, then start with bin_in=0 -> done pulses 13 cycles after accept; bcd_out=16'h0000; busy high for exactly 13 cycles.
- bin_in=8191 (max) -> bcd_out=16'h8191. bin_in=1234 -> 16'h1234. bin_in=3300 -> 16'h3300. Each result arrives with a single-cycle done pulse.
- Accept bin_in=4095, then pulse start with bin_in=7 at cycle 5 and change bin_in mid-conversion -> result 16'h4095, only one done pulse, second start ignored.
- Hold start=1 continuously with bin_in=10, then 999 -> done every 14 cycles; bcd_out=16'h0010, then 16'h0999; no idle gap cycles.
- Assert reset_n=0 at cycle 6 of converting 5000 (prior bcd_out=16'h1234) -> immediately busy=0, done=0, bcd_out=0; after release, no done pulse until a new start.
- Sweep bin_in=0..8191 with back-to-back starts -> every bcd_out matches the reference decimal model and all digits are <= 9.
